mc_seq_ctrl: RTL

- Multi-cycle sequencer for the RV32I core; replaces single-cycle decode when instruction and data memories have variable latency.
- Steps each instruction through fetch, decode, execute, memory and writeback, with valid/ready handshakes to imem/dmem.
- Drives the datapath enables and muxes (PC, IR, register file, ALU, writeback select).
- Traps illegal opcodes and memory timeouts into a sticky fault state.

---
 rtl/mc_seq_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with imem/dmem handshakes and a sticky fault state.
// Define MC_SEQ_PERF_EN to add the cycle_cnt/instret_cnt performance counters.
module mc_seq_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_we,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic       alu_a_pc,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       instr_done,
`ifdef MC_SEQ_PERF_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt,
`endif
  output logic       fault
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT} state_t;
  typedef enum logic [3:0] {C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_JALR, C_ILL} cls_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  function automatic cls_t classify(input logic [6:0] op);
    case (op)
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BRANCH;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      default:    return C_ILL;
    endcase
  endfunction

  // {alu_op, alu_src, alu_a_pc}
  function automatic logic [3:0] alu_ctl(input cls_t c);
    case (c)
      C_R:      return 4'b1000;
      C_I:      return 4'b1110;
      C_BRANCH: return 4'b0100;
      C_AUIPC:  return 4'b0011;
      default:  return 4'b0010;
    endcase
  endfunction

  function automatic logic [1:0] wb_of(input cls_t c);
    case (c)
      C_LOAD:         return 2'b01;
      C_JAL, C_JALR:  return 2'b10;
      C_LUI:          return 2'b11;
      default:        return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] pcsrc_of(input cls_t c);
    case (c)
      C_JAL:   return 2'b01;
      C_JALR:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  state_t          state;
  cls_t            cls;
  cls_t            dec_cls;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            pc_we_r, done_r, br_exec, st_mem;
  logic [1:0]      pc_src_r;

  assign dec_cls = classify(opcode);
  assign to_hit  = (MEM_TIMEOUT != 0) && (to_cnt == TO_LAST);

  // Strobes that must react within the cycle of a handshake or branch resolution.
  assign ir_we      = imem_req & imem_ready;
  assign pc_we      = pc_we_r | (st_mem & dmem_ready);
  assign instr_done = done_r | (st_mem & dmem_ready);
  assign pc_src     = br_exec ? {1'b0, br_taken} : pc_src_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      cls      <= C_R;
      to_cnt   <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      rf_we    <= 1'b0;
      wb_sel   <= 2'b00;
      alu_op   <= 2'b00;
      alu_src  <= 1'b0;
      alu_a_pc <= 1'b0;
      pc_we_r  <= 1'b0;
      pc_src_r <= 2'b00;
      done_r   <= 1'b0;
      br_exec  <= 1'b0;
      st_mem   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      rf_we    <= 1'b0;
      wb_sel   <= 2'b00;
      pc_we_r  <= 1'b0;
      pc_src_r <= 2'b00;
      done_r   <= 1'b0;
      br_exec  <= 1'b0;
      st_mem   <= 1'b0;
      case (state)
        S_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ready) begin
            state <= S_DECODE;
          end else if (to_hit) begin
            state <= S_FAULT;
            fault <= 1'b1;
          end else begin
            imem_req <= 1'b1;
            to_cnt   <= to_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          cls <= dec_cls;
          if (dec_cls == C_ILL) begin
            state <= S_FAULT;
            fault <= 1'b1;
          end else begin
            state <= S_EXEC;
            {alu_op, alu_src, alu_a_pc} <= alu_ctl(dec_cls);
            // Branches retire in EXEC; only the PC source waits for br_taken.
            if (dec_cls == C_BRANCH) begin
              pc_we_r <= 1'b1;
              done_r  <= 1'b1;
              br_exec <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (cls == C_LOAD || cls == C_STORE) begin
            state    <= S_MEM;
            dmem_req <= 1'b1;
            dmem_we  <= (cls == C_STORE);
            st_mem   <= (cls == C_STORE);
            to_cnt   <= '0;
          end else if (cls == C_BRANCH) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            to_cnt   <= '0;
            {alu_op, alu_src, alu_a_pc} <= 4'b0000;
          end else begin
            state    <= S_WB;
            rf_we    <= 1'b1;
            pc_we_r  <= 1'b1;
            done_r   <= 1'b1;
            wb_sel   <= wb_of(cls);
            pc_src_r <= pcsrc_of(cls);
          end
        end
        S_MEM: begin
          if (dmem_ready && cls == C_LOAD) begin
            state    <= S_WB;
            rf_we    <= 1'b1;
            pc_we_r  <= 1'b1;
            done_r   <= 1'b1;
            wb_sel   <= wb_of(cls);
            pc_src_r <= pcsrc_of(cls);
          end else if (dmem_ready) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            to_cnt   <= '0;
            {alu_op, alu_src, alu_a_pc} <= 4'b0000;
          end else if (to_hit) begin
            state <= S_FAULT;
            fault <= 1'b1;
            {alu_op, alu_src, alu_a_pc} <= 4'b0000;
          end else begin
            dmem_req <= 1'b1;
            dmem_we  <= (cls == C_STORE);
            st_mem   <= (cls == C_STORE);
            to_cnt   <= to_cnt + 1'b1;
          end
        end
        S_WB: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
          to_cnt   <= '0;
          {alu_op, alu_src, alu_a_pc} <= 4'b0000;
        end
        default: begin
          state <= S_FAULT;
          fault <= 1'b1;
        end
      endcase
    end
  end

`ifdef MC_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if (state != S_FAULT) cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_done) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule
